bus_arb: RTL
============

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter N_HARTS, default 2, number of hart ports (2..8).
REQ-002 SHALL have parameter LINE_W, default `hmem_line, line width in bits.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port h_addr  in  64*N_HARTS  per-hart line address, hart i at bits [64i+63:64i].
REQ-006 SHALL have port h_rd  in  N_HARTS  per-hart read request.
REQ-007 SHALL have port h_wr  in  N_HARTS  per-hart write request.
REQ-008 SHALL have port h_data_out  in  LINE_W*N_HARTS  per-hart write line.
REQ-009 SHALL have port h_data_in  out  LINE_W  read line, shared by all harts.
REQ-010 SHALL have port h_dv  out  N_HARTS  one-hot done strobe.
REQ-011 SHALL have port h_inv_addr  out  64  invalidate address, shared by all harts.
REQ-012 SHALL have port h_inv  out  N_HARTS  per-hart invalidate strobe.
REQ-013 SHALL have port h_amo_req  in  N_HARTS  per-hart AMO lock request.
REQ-014 SHALL have port h_amo_ack  out  N_HARTS  one-hot lock grant.
REQ-015 SHALL have ports m_addr out 64, m_rd out 1, m_wr out 1, m_data_out out LINE_W, m_data_in in LINE_W, m_dv in 1, for the memory side.

Function
REQ-016 SHALL use FSM states IDLE, GRANT, WAIT, DONE.
REQ-017 IDLE: SHALL remain while no eligible request exists; eligible = h_rd|h_wr, masked to the lock holder while a lock is held.
REQ-018 IDLE->GRANT: SHALL pick a winner round-robin, starting one above the last winner, and latch its index, address, data and op; h_wr takes priority over h_rd.
REQ-019 GRANT: SHALL drive m_rd or m_wr high for exactly one cycle with the latched m_addr/m_data_out, then go to WAIT.
REQ-020 WAIT: SHALL hold until m_dv=1, latch m_data_in on reads, then go to DONE.
REQ-021 DONE: SHALL pulse h_dv[winner] for one cycle with h_data_in valid, then return to IDLE; minimum request-to-h_dv latency is 3 cycles plus memory latency.
REQ-022 On a write, in the DONE cycle, SHALL set h_inv_addr=latched address and pulse h_inv to every hart except the writer.
REQ-023 SHALL ignore m_dv outside WAIT.
REQ-024 Lock: SHALL assert h_amo_ack[i] only in IDLE, only when no lock is held, choosing round-robin among h_amo_req; the grant SHALL hold until h_amo_req[i] falls and SHALL then release in the next cycle.
REQ-025 Lock held: the holder's bus requests SHALL still be served; other harts' requests SHALL be stalled without loss.
REQ-026 Lock grant vs. bus grant in the same IDLE cycle: the bus grant SHALL proceed and the lock grant SHALL defer to the next IDLE.
REQ-027 The round-robin pointer SHALL wrap from N_HARTS-1 to 0.

Reset
REQ-028 rst SHALL force IDLE, clear the lock, set the pointer to 0, and drive all outputs 0 (h_data_in and h_inv_addr included) in the following cycle, aborting any transaction in flight.

Configuration
REQ-029 With BUS_ARB_INV_EN defined, REQ-022 SHALL apply; when undefined, h_inv SHALL be tied 0, h_inv_addr 0, and no invalidate logic shall be built.

Structure
REQ-030 Package bus_pkg SHALL hold the FSM state encoding and the op encoding (OP_RD, OP_WR).
REQ-031 Sub-module rr_arb (N-input round-robin, request vector plus pointer in, one-hot grant out) SHALL be used twice: bus and lock.

Verification
REQ-032 Hart0 h_rd addr 0x1000, m_dv 2 cycles after m_rd -> m_rd one cycle with m_addr 0x1000; h_dv=2'b01 with line; no h_inv.
REQ-033 Hart0 and hart1 h_rd in the same cycle, pointer 0 -> hart1 served first, then hart0; exactly two m_rd pulses.
REQ-034 Hart1 h_wr addr 0x2040 (BUS_ARB_INV_EN) -> m_wr one cycle; in the DONE cycle h_inv=2'b01, h_inv_addr 0x2040; undefined: h_inv stays 0.
REQ-035 Hart0 holds h_amo_ack while hart1 h_rd and hart0 h_rd are pending -> hart0 served; hart1 served only after hart0 drops h_amo_req.
REQ-036 rst asserted during WAIT, then late m_dv -> FSM in IDLE, no h_dv, all outputs 0.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: state and op encodings shared by the bus_arb line arbiter.
// The top-level line width default comes from the hmem_line macro.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int ADDR_W = 64;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: N-input round-robin arbiter with a one-hot grant.
// The search starts one above ptr_i (the last winner) and wraps to 0.
module rr_arb #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = ptr_i;
        for (int k = 0; k < N; k++) begin
            idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb.sv
// bus_arb: round-robin line-bus arbiter for N harts with an AMO bus lock.
// Define BUS_ARB_INV_EN to build write-invalidate broadcast to other harts.
`ifndef HMEM_LINE
`define HMEM_LINE 512
`endif

module bus_arb
    import bus_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int LINE_W  = `HMEM_LINE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [64*N_HARTS-1:0]       h_addr,
    input  logic [N_HARTS-1:0]          h_rd,
    input  logic [N_HARTS-1:0]          h_wr,
    input  logic [LINE_W*N_HARTS-1:0]   h_data_out,
    output logic [LINE_W-1:0]           h_data_in,
    output logic [N_HARTS-1:0]          h_dv,
    output logic [63:0]                 h_inv_addr,
    output logic [N_HARTS-1:0]          h_inv,
    input  logic [N_HARTS-1:0]          h_amo_req,
    output logic [N_HARTS-1:0]          h_amo_ack,
    output logic [63:0]                 m_addr,
    output logic                        m_rd,
    output logic                        m_wr,
    output logic [LINE_W-1:0]           m_data_out,
    input  logic [LINE_W-1:0]           m_data_in,
    input  logic                        m_dv
);

    localparam int IW = $clog2(N_HARTS);
    localparam logic [N_HARTS-1:0] ONE = {{(N_HARTS-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [IW-1:0]       win_q, win_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [63:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                lk_q, lk_d;
    logic [IW-1:0]       lk_id_q, lk_id_d;
    logic [IW-1:0]       lk_ptr_q, lk_ptr_d;

    logic [N_HARTS-1:0]  mask, elig, bus_gnt, lk_gnt;
    logic [IW-1:0]       bus_idx, lk_idx;

    // While a lock is held only the holder may reach the bus.
    assign mask = lk_q ? (ONE << lk_id_q) : '1;
    assign elig = (h_rd | h_wr) & mask;

    rr_arb #(.N(N_HARTS)) u_bus_rr (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (bus_gnt)
    );

    rr_arb #(.N(N_HARTS)) u_lock_rr (
        .req_i (h_amo_req),
        .ptr_i (lk_ptr_q),
        .gnt_o (lk_gnt)
    );

    always_comb begin
        bus_idx = '0;
        lk_idx  = '0;
        for (int i = 0; i < N_HARTS; i++) begin
            if (bus_gnt[i]) bus_idx = IW'(i);
            if (lk_gnt[i])  lk_idx  = IW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        lk_d     = lk_q;
        lk_id_d  = lk_id_q;
        lk_ptr_d = lk_ptr_q;
        unique case (state_q)
            IDLE: if (|elig) begin
                state_d = GRANT;
                win_d   = bus_idx;
                ptr_d   = bus_idx;
                addr_d  = h_addr[int'(bus_idx)*64 +: 64];
                wdata_d = h_data_out[int'(bus_idx)*LINE_W +: LINE_W];
                op_d    = h_wr[bus_idx] ? OP_WR : OP_RD;
            end
            GRANT: state_d = WAIT;
            WAIT: if (m_dv) begin
                if (op_q == OP_RD) rdata_d = m_data_in;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
        // A bus grant in the same IDLE cycle wins; the lock waits.
        if (lk_q) begin
            if (!h_amo_req[lk_id_q]) lk_d = 1'b0;
        end else if (state_q == IDLE && !(|elig) && (|h_amo_req)) begin
            lk_d     = 1'b1;
            lk_id_d  = lk_idx;
            lk_ptr_d = lk_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_RD;
            win_q    <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            lk_q     <= 1'b0;
            lk_id_q  <= '0;
            lk_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            lk_q     <= lk_d;
            lk_id_q  <= lk_id_d;
            lk_ptr_q <= lk_ptr_d;
        end
    end

    assign m_addr     = addr_q;
    assign m_data_out = wdata_q;
    assign m_rd       = (state_q == GRANT) && (op_q == OP_RD);
    assign m_wr       = (state_q == GRANT) && (op_q == OP_WR);
    assign h_data_in  = rdata_q;
    assign h_dv       = (state_q == DONE) ? (ONE << win_q) : '0;
    assign h_amo_ack  = lk_q ? (ONE << lk_id_q) : '0;

`ifdef BUS_ARB_INV_EN
    logic wr_done;
    assign wr_done    = (state_q == DONE) && (op_q == OP_WR);
    assign h_inv      = wr_done ? ~(ONE << win_q) : '0;
    assign h_inv_addr = wr_done ? addr_q : '0;
`else
    assign h_inv      = '0;
    assign h_inv_addr = '0;
`endif

endmodule
